// File: rtl/glitch_pkg.sv
// Shared types for the glitch timing core: FSM states, default widths and the config snapshot.
package glitch_pkg;
    localparam int DEF_DELAY_W     = 24;
    localparam int DEF_WIDTH_W     = 16;
    localparam int DEF_COUNT_W     = 8;
    localparam int DEF_RESET_W     = 16;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        RST_ONLY,
        ARMED,
        DELAY,
        PULSE,
        GAP
    } state_e;

    typedef struct packed {
        logic [DEF_DELAY_W-1:0] delay;
        logic [DEF_WIDTH_W-1:0] width;
        logic [DEF_WIDTH_W-1:0] gap;
        logic [DEF_COUNT_W-1:0] count;
        logic [DEF_RESET_W-1:0] reset_len;
        logic                   edge_fall;
        logic                   arm_reset;
    } cfg_t;
endpackage

// File: rtl/glitch_sequencer_if.sv
// Command/config bundle from the register decoder and status/pin outputs of the sequencer.
interface glitch_sequencer_if
    import glitch_pkg::*;
#(
    parameter int DELAY_W = DEF_DELAY_W,
    parameter int WIDTH_W = DEF_WIDTH_W,
    parameter int COUNT_W = DEF_COUNT_W,
    parameter int RESET_W = DEF_RESET_W
);
    logic [DELAY_W-1:0] cfg_delay;
    logic [WIDTH_W-1:0] cfg_width;
    logic [WIDTH_W-1:0] cfg_gap;
    logic [COUNT_W-1:0] cfg_count;
    logic [RESET_W-1:0] cfg_reset_len;
    logic               cfg_edge;
    logic               cfg_arm_reset;
    logic               cmd_arm;
    logic               cmd_reset;
    logic               cmd_abort;
    logic               pulse_out;
    logic               pulse_en;
    logic               target_reset;
    logic               busy;
    logic               armed;
    logic               done;

    modport master (
        output cfg_delay, cfg_width, cfg_gap, cfg_count, cfg_reset_len, cfg_edge, cfg_arm_reset,
        output cmd_arm, cmd_reset, cmd_abort,
        input  pulse_out, pulse_en, target_reset, busy, armed, done
    );

    modport slave (
        input  cfg_delay, cfg_width, cfg_gap, cfg_count, cfg_reset_len, cfg_edge, cfg_arm_reset,
        input  cmd_arm, cmd_reset, cmd_abort,
        output pulse_out, pulse_en, target_reset, busy, armed, done
    );
endinterface

// File: rtl/trig_sync_edge.sv
// Trigger synchroniser with history flop and polarity-selected edge strobe.
// Latency: edge_o high in the cycle after the input reaches the last sync stage.
// Backpressure: none; free-running.
module trig_sync_edge
    import glitch_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic edge_sel,
    output logic edge_o
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        hist_d = sync_out;
    end

    // edge_sel=0 picks 0->1 transitions, edge_sel=1 picks 1->0.
    assign edge_o = (sync_out ^ hist_q) & (sync_out ^ edge_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end
endmodule

// File: rtl/glitch_sequencer.sv
// Glitch timing FSM: arm, optional target reset, trigger wait, delay, pulse train.
// Latency: first pulse_out high after edge k+SYNC_STAGES+delay for trigger sampled at edge k.
// Backpressure: none; commands outside IDLE are dropped, cmd_abort always wins.
module glitch_sequencer
    import glitch_pkg::*;
#(
    parameter int DELAY_W     = DEF_DELAY_W,
    parameter int WIDTH_W     = DEF_WIDTH_W,
    parameter int COUNT_W     = DEF_COUNT_W,
    parameter int RESET_W     = DEF_RESET_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trigger_in,
    glitch_sequencer_if.slave io
);
    localparam int DW_MAX = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;
    localparam int CNT_W  = (DW_MAX > RESET_W) ? DW_MAX : RESET_W;
    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [COUNT_W-1:0] rep_t;

    function automatic cnt_t len_m1(input cnt_t v);
        return (v == '0) ? '0 : v - cnt_t'(1);
    endfunction

    state_e state_q, state_d;
    cfg_t   cfg_q, cfg_d, cfg_in;
    cnt_t   cnt_q, cnt_d;
    rep_t   rep_q, rep_d;
    logic   fire, trig_edge;
    logic   pulse_out_q, pulse_out_d, pulse_en_q, pulse_en_d;
    logic   target_reset_q, target_reset_d, busy_q, busy_d;
    logic   armed_q, armed_d, done_q, done_d;

    trig_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_trig (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (trigger_in),
        .edge_sel (cfg_q.edge_fall),
        .edge_o   (trig_edge)
    );

    always_comb begin
        cfg_in.delay     = io.cfg_delay;
        cfg_in.width     = io.cfg_width;
        cfg_in.gap       = io.cfg_gap;
        cfg_in.count     = io.cfg_count;
        cfg_in.reset_len = io.cfg_reset_len;
        cfg_in.edge_fall = io.cfg_edge;
        cfg_in.arm_reset = io.cfg_arm_reset;
    end

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        done_d  = 1'b0;
        fire    = 1'b0;
        if (io.cmd_abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (io.cmd_arm) begin
                        cfg_d   = cfg_in;
                        state_d = io.cfg_arm_reset ? RST : ARMED;
                    end else if (io.cmd_reset) begin
                        cfg_d   = cfg_in;
                        state_d = RST_ONLY;
                    end
                end
                // Reset length counts up from 0 so the snapshot length is the only reference.
                RST, RST_ONLY: begin
                    if (cnt_q >= len_m1(cnt_t'(cfg_q.reset_len))) begin
                        state_d = (state_q == RST && cfg_q.arm_reset) ? ARMED : IDLE;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
                ARMED: begin
                    if (trig_edge) begin
                        rep_d = (cfg_q.count == '0) ? '0 : rep_t'(cfg_q.count) - rep_t'(1);
                        if (cfg_q.delay == '0) begin
                            fire = 1'b1;
                        end else begin
                            state_d = DELAY;
                            cnt_d   = cnt_t'(cfg_q.delay) - cnt_t'(1);
                        end
                    end
                end
                DELAY, GAP: begin
                    if (cnt_q == '0) fire = 1'b1;
                    else             cnt_d = cnt_q - cnt_t'(1);
                end
                PULSE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - cnt_t'(1);
                    end else if (rep_q != '0) begin
                        state_d = GAP;
                        cnt_d   = len_m1(cnt_t'(cfg_q.gap));
                        rep_d   = rep_q - rep_t'(1);
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            // A zero width means no pulse at all: the train ends where it would have started.
            if (fire) begin
                if (cfg_q.width == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = PULSE;
                    cnt_d   = cnt_t'(cfg_q.width) - cnt_t'(1);
                end
            end
        end
        pulse_out_d    = (state_d == PULSE);
        pulse_en_d     = state_d inside {ARMED, DELAY, PULSE, GAP};
        target_reset_d = state_d inside {RST, RST_ONLY};
        busy_d         = (state_d != IDLE);
        armed_d        = (state_d == ARMED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cfg_q          <= '0;
            cnt_q          <= '0;
            rep_q          <= '0;
            pulse_out_q    <= 1'b0;
            pulse_en_q     <= 1'b0;
            target_reset_q <= 1'b0;
            busy_q         <= 1'b0;
            armed_q        <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cfg_q          <= cfg_d;
            cnt_q          <= cnt_d;
            rep_q          <= rep_d;
            pulse_out_q    <= pulse_out_d;
            pulse_en_q     <= pulse_en_d;
            target_reset_q <= target_reset_d;
            busy_q         <= busy_d;
            armed_q        <= armed_d;
            done_q         <= done_d;
        end
    end

    assign io.pulse_out    = pulse_out_q;
    assign io.pulse_en     = pulse_en_q;
    assign io.target_reset = target_reset_q;
    assign io.busy         = busy_q;
    assign io.armed        = armed_q;
    assign io.done         = done_q;
endmodule

// File: tb/tb_glitch_sequencer.sv
// Bench for glitch_sequencer: vector table, hand-written corner sequences, randomized trains vs a timing model.
module tb_glitch_sequencer;
    import glitch_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic trigger_in = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    glitch_sequencer_if io ();

    glitch_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trigger_in (trigger_in),
        .io         (io)
    );

    typedef struct {
        int delay;
        int width;
        int gap;
        int count;
        bit edge_fall;
        int exp_first;
        int exp_high;
        int exp_done;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference timing: offsets counted in clock edges from the edge that first samples the trigger change.
    function automatic int m_pulses(input vec_t v);
        return (v.count == 0) ? 1 : v.count;
    endfunction

    function automatic int m_gap(input vec_t v);
        return (v.gap == 0) ? 1 : v.gap;
    endfunction

    function automatic int m_done(input vec_t v);
        if (v.width == 0) return 2 + v.delay;
        return 2 + v.delay + m_pulses(v) * v.width + (m_pulses(v) - 1) * m_gap(v);
    endfunction

    function automatic bit m_pulse(input vec_t v, input int j);
        int p, per;
        p   = j - (2 + v.delay);
        per = v.width + m_gap(v);
        if (v.width == 0 || p < 0) return 1'b0;
        if (p / per >= m_pulses(v)) return 1'b0;
        return (p % per) < v.width;
    endfunction

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cfg(input vec_t v);
        io.cfg_delay = DEF_DELAY_W'(v.delay);
        io.cfg_width = DEF_WIDTH_W'(v.width);
        io.cfg_gap   = DEF_WIDTH_W'(v.gap);
        io.cfg_count = DEF_COUNT_W'(v.count);
        io.cfg_edge  = v.edge_fall;
    endtask

    task automatic scramble_cfg();
        io.cfg_delay     = DEF_DELAY_W'($urandom);
        io.cfg_width     = DEF_WIDTH_W'($urandom);
        io.cfg_gap       = DEF_WIDTH_W'($urandom);
        io.cfg_count     = DEF_COUNT_W'($urandom);
        io.cfg_reset_len = DEF_RESET_W'($urandom);
        io.cfg_edge      = 1'($urandom);
        io.cfg_arm_reset = 1'($urandom);
    endtask

    task automatic abort_now();
        io.cmd_abort = 1'b1;
        @(negedge clk);
        io.cmd_abort = 1'b0;
    endtask

    // Entered and left at a negedge; leaves the block ARMED.
    task automatic arm_seq(input vec_t v, input int rlen, input bit arst);
        set_cfg(v);
        io.cfg_reset_len = DEF_RESET_W'(rlen);
        io.cfg_arm_reset = arst;
        io.cmd_arm       = 1'b1;
        @(negedge clk);
        io.cmd_arm = 1'b0;
        scramble_cfg();
        if (arst) begin
            for (int j = 0; j < ((rlen == 0) ? 1 : rlen); j++) begin
                chk($sformatf("target_reset@%0d", j), io.target_reset, 1);
                chk($sformatf("armed_in_rst@%0d", j), io.armed, 0);
                chk($sformatf("busy_in_rst@%0d", j), io.busy, 1);
                @(negedge clk);
            end
        end
        chk("armed_after_arm", io.armed, 1);
        chk("target_reset_after_arm", io.target_reset, 0);
    endtask

    // Toggles the trigger and checks every cycle until past done; inj places ignored commands mid-run.
    task automatic fire(input vec_t v, input int inj, output int first, output int high, output int done_at);
        int dn;
        dn      = m_done(v);
        first   = -1;
        high    = 0;
        done_at = -1;
        trigger_in = ~trigger_in;
        for (int j = 0; j <= dn + 2; j++) begin
            @(negedge clk);
            chk($sformatf("pulse_out@%0d", j), io.pulse_out, m_pulse(v, j));
            chk($sformatf("done@%0d", j), io.done, j == dn);
            chk($sformatf("busy@%0d", j), io.busy, j < dn);
            chk($sformatf("pulse_en@%0d", j), io.pulse_en, j < dn);
            chk($sformatf("armed@%0d", j), io.armed, j < 2);
            if (io.pulse_out && first < 0) first = j;
            if (io.pulse_out) high++;
            if (io.done && done_at < 0) done_at = j;
            io.cmd_arm   = (j == inj) && (j < dn);
            io.cmd_reset = (j == inj + 1) && (j < dn);
        end
        io.cmd_arm   = 1'b0;
        io.cmd_reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int rlen, input bit arst, input int inj,
                           output int first, output int high, output int done_at);
        trigger_in = v.edge_fall;
        settle(4);
        arm_seq(v, rlen, arst);
        fire(v, inj, first, high, done_at);
        trigger_in = ~trigger_in;
        settle(4);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        vec_t v;
        int   first, high, done_at;

        tbl[0] = '{10, 5, 0, 1, 1'b0, 12, 5, 17};
        tbl[1] = '{0,  1, 2, 3, 1'b0,  2, 3,  9};
        tbl[2] = '{3,  2, 0, 2, 1'b0,  5, 4, 10};
        tbl[3] = '{1,  0, 0, 5, 1'b0, -1, 0,  3};
        tbl[4] = '{2,  3, 1, 0, 1'b1,  4, 3,  7};
        tbl[5] = '{0,  4, 3, 2, 1'b0,  2, 8, 13};

        io.cmd_arm = 1'b0;
        io.cmd_reset = 1'b0;
        io.cmd_abort = 1'b0;
        io.cfg_arm_reset = 1'b0;
        io.cfg_reset_len = '0;
        set_cfg(tbl[0]);

        #12;
        chk("rst_pulse_out", io.pulse_out, 0);
        chk("rst_pulse_en", io.pulse_en, 0);
        chk("rst_target_reset", io.target_reset, 0);
        chk("rst_busy", io.busy, 0);
        chk("rst_armed", io.armed, 0);
        chk("rst_done", io.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        settle(2);
        chk("idle_busy", io.busy, 0);

        for (int i = 0; i < 6; i++) begin
            run_vec(tbl[i], 0, 1'b0, -1, first, high, done_at);
            chk($sformatf("tbl%0d_first", i), first, tbl[i].exp_first);
            chk($sformatf("tbl%0d_high", i), high, tbl[i].exp_high);
            chk($sformatf("tbl%0d_done", i), done_at, tbl[i].exp_done);
        end

        // Arm with target reset; a trigger blip during the reset must be ignored.
        v = '{5, 2, 0, 1, 1'b0, 0, 0, 0};
        trigger_in = 1'b0;
        settle(4);
        set_cfg(v);
        io.cfg_arm_reset = 1'b1;
        io.cfg_reset_len = 4;
        io.cmd_arm = 1'b1;
        @(negedge clk);
        io.cmd_arm = 1'b0;
        trigger_in = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("arst_target_reset@%0d", j), io.target_reset, 1);
            chk($sformatf("arst_armed@%0d", j), io.armed, 0);
            if (j == 0) trigger_in = 1'b0;
            @(negedge clk);
        end
        chk("arst_armed_after", io.armed, 1);
        chk("arst_target_reset_after", io.target_reset, 0);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk($sformatf("arst_no_pulse@%0d", j), io.pulse_out, 0);
            chk($sformatf("arst_still_armed@%0d", j), io.armed, 1);
        end
        fire(v, -1, first, high, done_at);
        chk("arst_high", high, 2);
        trigger_in = 1'b0;
        settle(4);

        // Falling mode: rising edge ignored, falling edge fires.
        v = '{4, 2, 1, 2, 1'b1, 0, 0, 0};
        arm_seq(v, 0, 1'b0);
        trigger_in = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk($sformatf("fall_rise_ignored@%0d", j), io.pulse_out, 0);
            chk($sformatf("fall_armed@%0d", j), io.armed, 1);
        end
        fire(v, -1, first, high, done_at);
        chk("fall_first", first, 6);
        settle(4);

        // Held-high trigger never refires after re-arm.
        v = '{0, 2, 0, 1, 1'b0, 0, 0, 0};
        arm_seq(v, 0, 1'b0);
        fire(v, -1, first, high, done_at);
        arm_seq(v, 0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk($sformatf("held_no_pulse@%0d", j), io.pulse_out, 0);
            chk($sformatf("held_armed@%0d", j), io.armed, 1);
        end
        abort_now();
        chk("held_abort_idle", io.busy, 0);
        trigger_in = 1'b0;
        settle(4);

        // Abort at the 20th cycle of a 100-cycle pulse; cmd_arm mid-pulse ignored.
        v = '{0, 100, 0, 1, 1'b0, 0, 0, 0};
        arm_seq(v, 0, 1'b0);
        trigger_in = 1'b1;
        high = 0;
        for (int j = 0; j <= 21; j++) begin
            @(negedge clk);
            if (io.pulse_out) high++;
            io.cmd_arm = (j == 10);
        end
        chk("abort_high_before", high, 20);
        abort_now();
        chk("abort_pulse_out", io.pulse_out, 0);
        chk("abort_busy", io.busy, 0);
        chk("abort_pulse_en", io.pulse_en, 0);
        chk("abort_done", io.done, 0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk($sformatf("abort_no_done@%0d", j), io.done, 0);
        end
        trigger_in = 1'b0;
        settle(4);

        // cmd_reset while ARMED ignored; cmd_reset in IDLE with length 0 gives one cycle.
        arm_seq(v, 0, 1'b0);
        io.cfg_reset_len = 5;
        io.cmd_reset = 1'b1;
        @(negedge clk);
        io.cmd_reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("armed_rst_ignored@%0d", j), io.target_reset, 0);
            chk($sformatf("armed_rst_armed@%0d", j), io.armed, 1);
            @(negedge clk);
        end
        abort_now();
        io.cfg_reset_len = 0;
        io.cmd_reset = 1'b1;
        @(negedge clk);
        io.cmd_reset = 1'b0;
        chk("rst_only_tr_on", io.target_reset, 1);
        chk("rst_only_armed", io.armed, 0);
        chk("rst_only_busy", io.busy, 1);
        @(negedge clk);
        chk("rst_only_tr_off", io.target_reset, 0);
        chk("rst_only_armed_after", io.armed, 0);
        chk("rst_only_busy_after", io.busy, 0);

        // cmd_arm beats a simultaneous cmd_reset.
        io.cfg_arm_reset = 1'b0;
        io.cmd_arm = 1'b1;
        io.cmd_reset = 1'b1;
        @(negedge clk);
        io.cmd_arm = 1'b0;
        io.cmd_reset = 1'b0;
        chk("arm_wins_armed", io.armed, 1);
        chk("arm_wins_tr", io.target_reset, 0);
        abort_now();

        // Async reset during DELAY and mid-pulse.
        v = '{30, 3, 0, 1, 1'b0, 0, 0, 0};
        arm_seq(v, 0, 1'b0);
        trigger_in = 1'b1;
        settle(6);
        chk("delay_busy_before_rst", io.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_delay_busy", io.busy, 0);
        chk("rst_delay_pulse_en", io.pulse_en, 0);
        chk("rst_delay_armed", io.armed, 0);
        chk("rst_delay_pulse_out", io.pulse_out, 0);
        @(negedge clk);
        trigger_in = 1'b0;
        rst_n = 1'b1;
        settle(4);
        v = '{0, 10, 0, 1, 1'b0, 0, 0, 0};
        arm_seq(v, 0, 1'b0);
        trigger_in = 1'b1;
        settle(5);
        chk("midpulse_high", io.pulse_out, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_midpulse_pulse_out", io.pulse_out, 0);
        chk("rst_midpulse_busy", io.busy, 0);
        @(negedge clk);
        trigger_in = 1'b0;
        rst_n = 1'b1;
        settle(4);

        // Randomized trains with config scrambled after arm and stray commands mid-run.
        for (int i = 0; i < 25; i++) begin
            bit arst;
            int rlen;
            v.delay     = $urandom_range(0, 40);
            v.width     = $urandom_range(0, 8);
            v.gap       = $urandom_range(0, 5);
            v.count     = $urandom_range(0, 4);
            v.edge_fall = 1'($urandom);
            arst        = 1'($urandom);
            rlen        = $urandom_range(0, 6);
            run_vec(v, rlen, arst, $urandom_range(0, 60), first, high, done_at);
            chk($sformatf("rnd%0d_done", i), done_at, m_done(v));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
